// File: rtl/stream_demux_buf.sv
// Registered 1-to-NUM_ELEM valid/ready demux with a 2-entry buffer per output channel.
// Define STREAM_DEMUX_BUF_DROP_CNT_EN to add drop_cnt_o, a saturating count of dropped out-of-range beats.
`timescale 1ns/1ps
module stream_demux_buf #(
    parameter int unsigned NUM_ELEM   = 6,
    parameter int unsigned ELEM_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic [$clog2(NUM_ELEM)-1:0]          sel_i,
    input  logic [ELEM_WIDTH-1:0]                data_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    output logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  data_o,
    output logic [NUM_ELEM-1:0]                  valid_o,
    input  logic [NUM_ELEM-1:0]                  ready_i,
    output logic                                 err_o
`ifdef STREAM_DEMUX_BUF_DROP_CNT_EN
    ,
    output logic [15:0]                          drop_cnt_o
`endif
);

    if (BUF_DEPTH != 2) begin : g_depth_check
        $error("stream_demux_buf: BUF_DEPTH must be 2");
    end

    logic [ELEM_WIDTH-1:0] mem [NUM_ELEM][2];
    logic [1:0]            cnt [NUM_ELEM];
    logic [NUM_ELEM-1:0]   wr_ptr;
    logic [NUM_ELEM-1:0]   rd_ptr;
    logic [NUM_ELEM-1:0]   push_vec;
    logic [NUM_ELEM-1:0]   pop_vec;
    logic [31:0]           sel_ext;
    logic                  in_range;
    logic                  sel_full;
    logic                  push;
    logic                  drop;

    assign sel_ext  = 32'(sel_i);
    assign in_range = sel_ext < NUM_ELEM;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel_full = 1'b0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (sel_ext == 32'(i)) sel_full = (cnt[i] == 2'd2);
        end
    end

    // Acceptance looks only at the selected channel's registered count, never at ready_i.
    assign ready_o = in_range ? ~sel_full : 1'b1;
    assign push    = valid_i & ready_o & in_range;
    assign drop    = valid_i & ~in_range;

    always_comb begin
        valid_o  = '0;
        data_o   = '0;
        push_vec = '0;
        pop_vec  = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            valid_o[i]  = (cnt[i] != 2'd0);
            data_o[i]   = mem[i][rd_ptr[i]];
            pop_vec[i]  = valid_o[i] & ready_i[i];
            push_vec[i] = push & (sel_ext == 32'(i));
        end
    end

    // NOTE: storage is cleared on reset too, so data_o reads 0 instead of stale beats.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err_o  <= 1'b0;
            for (int i = 0; i < NUM_ELEM; i++) begin
                cnt[i]    <= 2'd0;
                mem[i][0] <= '0;
                mem[i][1] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates make every register sample pre-edge values, independent of statement order.
            err_o <= drop;
            for (int i = 0; i < NUM_ELEM; i++) begin
                if (push_vec[i]) begin
                    mem[i][wr_ptr[i]] <= data_i;
                    wr_ptr[i]         <= ~wr_ptr[i];
                end
                if (pop_vec[i]) rd_ptr[i] <= ~rd_ptr[i];
                if (push_vec[i] && !pop_vec[i])      cnt[i] <= cnt[i] + 2'd1;
                else if (!push_vec[i] && pop_vec[i]) cnt[i] <= cnt[i] - 2'd1;
            end
        end
    end

`ifdef STREAM_DEMUX_BUF_DROP_CNT_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            drop_cnt_o <= 16'h0000;
        end else if (drop && drop_cnt_o != 16'hFFFF) begin
            drop_cnt_o <= drop_cnt_o + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux_buf.sv
// Scoreboard bench for stream_demux_buf: directed beats push expected data per channel,
// a negedge monitor pops and compares whenever a channel hands off a beat.
`timescale 1ns/1ps
module tb_stream_demux_buf;

    logic            clk_i = 1'b0;
    logic            arst_ni;
    logic [2:0]      sel_i;
    logic [7:0]      data_i;
    logic            valid_i;
    logic            ready_o;
    logic [5:0][7:0] data_o;
    logic [5:0]      valid_o;
    logic [5:0]      ready_i;
    logic            err_o;
`ifdef STREAM_DEMUX_BUF_DROP_CNT_EN
    logic [15:0]     drop_cnt_o;
`endif

    stream_demux_buf #(.NUM_ELEM(6), .ELEM_WIDTH(8), .BUF_DEPTH(2)) dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .sel_i   (sel_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .err_o   (err_o)
`ifdef STREAM_DEMUX_BUF_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [7:0] exp_q [6][$];
    int         err_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Monitor: a beat leaves channel i at the next edge when valid_o[i] & ready_i[i].
    always @(negedge clk_i) begin
        if (arst_ni) begin
            for (int i = 0; i < 6; i++) begin
                if (valid_o[i] && ready_i[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL ch%0d_unexpected: got beat %0h, expected none", i, data_o[i]);
                    end else begin
                        check($sformatf("ch%0d_data", i), 64'(data_o[i]), 64'(exp_q[i].pop_front()));
                    end
                end
            end
            if (err_q.size() != 0 && err_q[0] == cyc) begin
                void'(err_q.pop_front());
                check("err_o", 64'(err_o), 64'd1);
            end else begin
                check("err_o", 64'(err_o), 64'd0);
            end
        end
    end

    // One cycle of a beat; exp_rdy is the hand-derived acceptance for that cycle.
    task automatic beat(input logic [2:0] sel, input logic [7:0] d, input bit exp_rdy);
        sel_i   = sel;
        data_i  = d;
        valid_i = 1'b1;
        @(negedge clk_i);
        check($sformatf("ready_o_sel%0d_%0h", sel, d), 64'(ready_o), 64'(exp_rdy));
        if (exp_rdy && sel < 3'd6) exp_q[sel].push_back(d);
        if (sel >= 3'd6) err_q.push_back(cyc + 1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        arst_ni = 1'b0;
        sel_i   = '0;
        data_i  = '0;
        valid_i = 1'b0;
        ready_i = '1;
        #3;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_data_o",  64'(data_o),  64'd0);
        check("rst_err_o",   64'(err_o),   64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        #9 arst_ni = 1'b1;
        idle(2);

        // Single beat to channel 3, one-cycle latency then drained.
        beat(3'd3, 8'hA5, 1'b1);
        @(negedge clk_i);
        check("t1_valid_o", 64'(valid_o), 64'b001000);
        check("t1_data3",   64'(data_o[3]), 64'hA5);
        @(negedge clk_i);
        check("t1_valid_o_after", 64'(valid_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Channel 2 fills while stalled; release drains in order, then third beat enters.
        ready_i = 6'b111011;
        beat(3'd2, 8'h11, 1'b1);
        beat(3'd2, 8'h22, 1'b1);
        beat(3'd2, 8'h33, 1'b0);
        ready_i = '1;
        beat(3'd2, 8'h33, 1'b0);
        beat(3'd2, 8'h33, 1'b1);
        idle(3);

        // Channel 1 full and stalled does not block channel 4.
        ready_i = 6'b111101;
        beat(3'd1, 8'hC1, 1'b1);
        beat(3'd1, 8'hC2, 1'b1);
        beat(3'd1, 8'hC3, 1'b0);
        beat(3'd4, 8'h41, 1'b1);
        beat(3'd4, 8'h42, 1'b1);
        @(negedge clk_i);
        check("t3_valid1", 64'(valid_o[1]), 64'd1);
        check("t3_data1",  64'(data_o[1]),  64'hC1);
        @(posedge clk_i);
        #1;
        ready_i = '1;
        idle(4);

        // Channel 0: pop and push in the same cycle keeps one entry, new beat is head.
        ready_i = 6'b111110;
        beat(3'd0, 8'h01, 1'b1);
        ready_i = '1;
        beat(3'd0, 8'h5A, 1'b1);
        @(negedge clk_i);
        check("t4_valid0", 64'(valid_o[0]), 64'd1);
        check("t4_data0",  64'(data_o[0]),  64'h5A);
        @(negedge clk_i);
        check("t4_valid0_after", 64'(valid_o[0]), 64'd0);
        @(posedge clk_i);
        #1;

        // Two back-to-back out-of-range beats.
        beat(3'd7, 8'hEE, 1'b1);
        beat(3'd7, 8'hEF, 1'b1);
        @(negedge clk_i);
        check("t5_valid_o", 64'(valid_o), 64'd0);
`ifdef STREAM_DEMUX_BUF_DROP_CNT_EN
        check("t5_drop_cnt", 64'(drop_cnt_o), 64'd2);
`endif
        @(posedge clk_i);
        #1;
        idle(2);

        // Asynchronous reset with three channels holding beats.
        ready_i = '0;
        beat(3'd0, 8'hA0, 1'b1);
        beat(3'd2, 8'hA2, 1'b1);
        beat(3'd5, 8'hA5, 1'b1);
        @(negedge clk_i);
        check("t6_valid_pre", 64'(valid_o), 64'b100101);
        #2 arst_ni = 1'b0;
        #1;
        check("t6_valid_rst", 64'(valid_o), 64'd0);
        check("t6_data_rst",  64'(data_o),  64'd0);
        for (int i = 0; i < 6; i++) exp_q[i].delete();
        ready_i = '1;
        #20 arst_ni = 1'b1;
        idle(4);
        sel_i = 3'd0;
        #1;
        check("t6_ready_post", 64'(ready_o), 64'd1);
        check("t6_valid_post", 64'(valid_o), 64'd0);

        for (int i = 0; i < 6; i++) check($sformatf("ch%0d_leftover", i), 64'(exp_q[i].size()), 64'd0);
        check("err_leftover", 64'(err_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_demux_buf.md
Name: stream_demux_buf

Overview:
- Handshaked, registered demultiplexer that routes one valid/ready input stream to one of NUM_ELEM output streams, selected per beat by sel_i.
- Each output channel has its own 2-entry buffer, so a stalled consumer blocks only beats addressed to it.
- Sits between a single producer and several independent consumers. It is the sequential successor of the combinational decoder-gated demux.

Parameters:
- NUM_ELEM, 6, number of output channels (>=2; need not be a power of two)
- ELEM_WIDTH, 8, data width of each beat
- BUF_DEPTH, 2, entries per output buffer (fixed at 2 in this revision; any other value is a elaboration error)

Ports:
- clk_i  input  1  clock, all state on rising edge
- arst_ni  input  1  asynchronous active-low reset
- sel_i  input  $clog2(NUM_ELEM)  target channel for current input beat
- data_i  input  ELEM_WIDTH  input beat data
- valid_i  input  1  input beat valid
- ready_o  output  1  input beat accepted when valid_i & ready_o
- data_o  output  NUM_ELEM x ELEM_WIDTH  per-channel head-of-buffer data
- valid_o  output  NUM_ELEM  per-channel buffer non-empty
- ready_i  input  NUM_ELEM  per-channel consumer ready
- err_o  output  1  one-cycle pulse: out-of-range beat was dropped

Behaviour:
- Reset (arst_ni low, async): all buffer counts and pointers = 0, all storage = 0, valid_o = 0, data_o = 0, err_o = 0.
  - Reset mid-operation discards all buffered beats. No beat is emitted after release until a new one is accepted.
- Per channel i: count[i] in 0..2, write pointer and read pointer each 1 bit, wrapping 1->0.
  - valid_o[i] = (count[i] != 0).
  - data_o[i] = entry at the read pointer, driven directly from storage.
- ready_o:
  - sel_i < NUM_ELEM: ready_o = (count[sel_i] != 2).
  - sel_i >= NUM_ELEM: ready_o = 1.
  - ready_o depends only on sel_i and registered counts, never on ready_i.
- Push: valid_i & ready_o & (sel_i < NUM_ELEM) writes data_i at the write pointer of channel sel_i. The write pointer advances and the count increments.
- Pop: valid_o[i] & ready_i[i] advances the read pointer of channel i and decrements its count.
- Simultaneous push and pop on the same channel: count is unchanged, both pointers advance.
  - A full channel (count 2) never accepts a push in the same cycle as its pop; ready_o is computed from the pre-pop count.
- Latency: a beat accepted in cycle N is visible on valid_o/data_o of its channel in cycle N+1 (buffer previously empty). Minimum one cycle, no combinational bypass.
- Ordering: beats to the same channel leave in acceptance order. There is no ordering relation between channels.
- Throughput: one beat per cycle into any non-full channel; full rate sustained per channel when its consumer holds ready_i = 1.
- Out-of-range select (sel_i >= NUM_ELEM, only possible when NUM_ELEM is not a power of two):
  - The beat is accepted and discarded; no channel state changes.
  - err_o = 1 in the following cycle only; back-to-back drops give err_o high in consecutive cycles.
- valid_i low: no push regardless of sel_i; err_o not asserted.
- Data path is pass-through: no width change and no modification of data_i.

Optional Feature:
- Macro: STREAM_DEMUX_BUF_DROP_CNT_EN
- Defined:
  - Adds output port drop_cnt_o, 16 bits.
  - It is a saturating count of dropped out-of-range beats, incremented in the same cycle err_o pulses, holding at 16'hFFFF.
  - Reset value 0, async cleared by arst_ni.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, then sel_i=3, data_i=8'hA5, valid_i=1 for one cycle, ready_i=all 1 -> next cycle valid_o=6'b001000, data_o[3]=8'hA5. Cycle after, valid_o=0.
- ready_i[2]=0, push 8'h11, 8'h22, 8'h33 to channel 2 back-to-back -> first two accepted, ready_o=0 on the third. Set ready_i[2]=1 -> 8'h11 then 8'h22 emitted in order, then 8'h33 accepted.
- Channel 1 full and stalled, then beats to channel 4 -> ready_o=1 for channel-4 beats, which emerge with 1-cycle latency; channel 1 contents are unchanged.
- Channel 0 holds one beat with ready_i[0]=1, same-cycle push of 8'h5A to channel 0 -> count stays 1, and 8'h5A is the head on the next cycle.
- sel_i=7 with NUM_ELEM=6, valid_i=1 for two cycles -> ready_o=1, err_o high for the 2 following cycles, no valid_o change. With the macro defined, drop_cnt_o=2.
- Assert arst_ni=0 while 3 channels are non-empty -> valid_o=0 immediately (asynchronously). After release, no stale beat appears.
